// File: rtl/spi_frame_scheduler.sv
// Frame-level scheduler feeding the SPI slave transmitter from two
// first-word-fall-through word sources (src0 trace, src1 status).
// A source holding at least one full frame of words is granted per frame.
// Its words are handed to the transmitter one per word request. When no
// source is granted, the transmitter sends empty frames.
module spi_frame_scheduler #(
   parameter int FRAME_WORDS = 8,
   parameter int COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [15:0]        src0_word,
   input  logic [COUNT_W-1:0] src0_count,
   output logic               src0_pop,
   input  logic [15:0]        src1_word,
   input  logic [COUNT_W-1:0] src1_count,
   output logic               src1_pop,
   input  logic               frame_sync,
   input  logic               word_req,
   output logic               transmit,
   output logic [15:0]        tx_word,
   output logic [1:0]         grant,
   output logic               underrun,
   output logic [15:0]        frames_sent
);

   localparam int WL_W = $clog2(FRAME_WORDS + 1);
   localparam logic [COUNT_W-1:0] FW_CNT = COUNT_W'(FRAME_WORDS);
   localparam logic [WL_W-1:0]    FW_WL  = WL_W'(FRAME_WORDS);
   localparam logic [WL_W-1:0]    WL_ONE = WL_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      SENDING = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [WL_W-1:0]   words_left, words_left_nxt;
   logic [1:0]        grant_nxt;
   logic              last_grant, last_grant_nxt;   // 1 = src1 owned the last frame
   logic [15:0]       tx_word_nxt;
   logic [15:0]       frames_sent_nxt;
   logic              pop0_c, pop1_c, underrun_c;
   logic              q0, q1, sel;
   logic [COUNT_W-1:0] cur_count;
   logic [15:0]       cur_word;

   // A source may only be granted when it already holds a whole frame.
   function automatic logic qualifies(input logic [COUNT_W-1:0] cnt);
      return cnt >= FW_CNT;
   endfunction

   // State and datapath registers; reset returns everything to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         words_left  <= '0;
         grant       <= 2'b00;
         last_grant  <= 1'b1;
         tx_word     <= '0;
         frames_sent <= '0;
      end else begin
         state       <= state_nxt;
         words_left  <= words_left_nxt;
         grant       <= grant_nxt;
         last_grant  <= last_grant_nxt;
         tx_word     <= tx_word_nxt;
         frames_sent <= frames_sent_nxt;
      end
   end

   // Next-state logic, pop strobes and underrun detection.
   always_comb begin
      state_nxt       = state;
      words_left_nxt  = words_left;
      grant_nxt       = grant;
      last_grant_nxt  = last_grant;
      tx_word_nxt     = tx_word;
      frames_sent_nxt = frames_sent;
      pop0_c          = 1'b0;
      pop1_c          = 1'b0;
      underrun_c      = 1'b0;
      sel             = 1'b0;
      q0              = qualifies(src0_count);
      q1              = qualifies(src1_count);
      cur_count       = grant[1] ? src1_count : src0_count;
      cur_word        = grant[1] ? src1_word  : src0_word;

      case (state)
         IDLE: begin
            if (enable && (q0 || q1)) begin
               // On a tie the source that did not own the last frame wins.
               sel         = (q0 && q1) ? ~last_grant : q1;
               pop0_c      = ~sel;
               pop1_c      = sel;
               tx_word_nxt = sel ? src1_word : src0_word;
               grant_nxt   = sel ? 2'b10 : 2'b01;
               state_nxt   = ARMED;
            end
         end
         ARMED: begin
            if (frame_sync) begin
               words_left_nxt = FW_WL;
               state_nxt      = SENDING;
            end
         end
         SENDING: begin
            if (frame_sync) begin
               // Transmitter re-synchronised: drop the frame without counting it.
               grant_nxt      = 2'b00;
               last_grant_nxt = grant[1];
               state_nxt      = IDLE;
            end else if (word_req) begin
               words_left_nxt = words_left - WL_ONE;
               if (words_left > WL_ONE) begin
                  if (cur_count == '0) begin
                     underrun_c  = 1'b1;
                     tx_word_nxt = '0;
                  end else begin
                     pop0_c      = grant[0];
                     pop1_c      = grant[1];
                     tx_word_nxt = cur_word;
                  end
               end else begin
                  frames_sent_nxt = frames_sent + 16'd1;
                  last_grant_nxt  = grant[1];
                  grant_nxt       = 2'b00;
                  state_nxt       = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign transmit = (state == ARMED);
   assign src0_pop = pop0_c & ~rst;
   assign src1_pop = pop1_c & ~rst;
   assign underrun = underrun_c & ~rst;

endmodule
